shift_register: RTL and testbench

Three-row line buffer for the Sobel edge-detection loader. It accepts one 8-bit pixel per enabled clock in raster order. Each enabled cycle it presents three vertically aligned pixels of the same column from three consecutive image rows. It feeds the 3x3 window/convolution stage downstream.

---
 rtl/shift_register.sv | 133 +++++++++++++
 tb/tb_shift_register.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/shift_register.sv
// shift_register -- three-row line buffer feeding the Sobel 3x3 window stage.
//
// Each enabled clock shifts one pixel into a continuous delay chain of
// 2*LINE_LEN+1 pixel stages.  The taps expose three vertically aligned pixels
// of the same column from three consecutive image rows.  Pixels flow straight
// across row boundaries; edge handling belongs to the downstream block.
//
// Optional feature macro: SHIFT_REGISTER_VALID_EN
//   defined   -> adds a saturating fill counter and the Valid output
//   undefined -> no counter, no Valid port
//
// Ports:
//   CLK       in   1       clock, all state updates on the rising edge
//   RST_n     in   1       asynchronous active-low reset, clears all state
//   Enable    in   1       shift strobe; DataIn accepted when 1
//   DataIn    in   DATA_W  incoming pixel, raster order
//   DataOut0  out  DATA_W  oldest row  (stage 2*LINE_LEN)
//   DataOut1  out  DATA_W  middle row  (stage LINE_LEN)
//   DataOut2  out  DATA_W  newest row  (stage 0, last accepted pixel)
//   Valid     out  1       window filled (SHIFT_REGISTER_VALID_EN only)

// One image row worth of delay: DEPTH register stages, output is the last one.
module shiftRowDelay #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 512
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              Enable,
  input  logic [DATA_W-1:0] rowIn,
  output logic [DATA_W-1:0] rowOut
);

  logic [DEPTH-1:0][DATA_W-1:0] stage;

  // Plain registers rather than RAM: the async reset must clear every stage.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      stage <= '0;
    end else if (Enable) begin
      stage[0] <= rowIn;
      for (int k = 1; k < DEPTH; k++) begin
        stage[k] <= stage[k-1];
      end
    end
  end

  assign rowOut = stage[DEPTH-1];

endmodule

module shift_register #(
  parameter int DATA_W   = 8,
  parameter int LINE_LEN = 512
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              Enable,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] DataOut0,
  output logic [DATA_W-1:0] DataOut1,
  output logic [DATA_W-1:0] DataOut2
`ifdef SHIFT_REGISTER_VALID_EN
  ,
  output logic              Valid
`endif
);

  localparam int NUM_ROWS = 2;

  generate
    if (LINE_LEN < 2 || LINE_LEN > 4096) begin : g_badLen
      $error("shift_register: LINE_LEN out of range 2..4096");
    end
  endgenerate

  // rowTap[0] = stage 0, rowTap[i] = stage i*LINE_LEN.
  logic [NUM_ROWS:0][DATA_W-1:0] rowTap;

  // Stage 0: registered so no output has a combinational path from DataIn.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      rowTap[0] <= '0;
    end else if (Enable) begin
      rowTap[0] <= DataIn;
    end
  end

  genvar r;
  generate
    for (r = 0; r < NUM_ROWS; r++) begin : g_row
      shiftRowDelay #(
        .DATA_W (DATA_W),
        .DEPTH  (LINE_LEN)
      ) u_row (
        .CLK    (CLK),
        .RST_n  (RST_n),
        .Enable (Enable),
        .rowIn  (rowTap[r]),
        .rowOut (rowTap[r+1])
      );
    end
  endgenerate

  assign DataOut2 = rowTap[0];
  assign DataOut1 = rowTap[1];
  assign DataOut0 = rowTap[2];

`ifdef SHIFT_REGISTER_VALID_EN
  localparam int FILL  = 2*LINE_LEN + 1;
  localparam int CNT_W = $clog2(FILL + 1);
  localparam logic [CNT_W-1:0] FILL_CNT = CNT_W'(FILL);

  logic [CNT_W-1:0] fillCnt;
  logic             validReg;

  // Counter saturates at FILL; Valid is set on the edge the counter reaches
  // FILL, i.e. the edge that first lands real data on DataOut0, and then
  // stays set until reset regardless of Enable.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      fillCnt  <= '0;
      validReg <= 1'b0;
    end else if (Enable && fillCnt != FILL_CNT) begin
      fillCnt <= fillCnt + 1'b1;
      if (fillCnt == FILL_CNT - 1'b1) validReg <= 1'b1;
    end
  end

  assign Valid = validReg;
`endif

endmodule

// File: tb/tb_shift_register.sv
// Bench for shift_register with LINE_LEN=4: a queue-based model of the
// accepted-pixel history checked every negative clock edge, plus directed
// vectors with hand-computed literal expectations.
module tb_shift_register;

  localparam int DW = 8;
  localparam int LL = 4;
  localparam int FILL = 2*LL + 1;

  logic          CLK = 1'b0;
  logic          RST_n = 1'b0;
  logic          Enable = 1'b0;
  logic [DW-1:0] DataIn = '0;
  logic [DW-1:0] DataOut0, DataOut1, DataOut2;
`ifdef SHIFT_REGISTER_VALID_EN
  logic          Valid;
`endif

  int nCmp = 0;
  int nBad = 0;

  shift_register #(.DATA_W(DW), .LINE_LEN(LL)) dut (
    .CLK      (CLK),
    .RST_n    (RST_n),
    .Enable   (Enable),
    .DataIn   (DataIn),
    .DataOut0 (DataOut0),
    .DataOut1 (DataOut1),
`ifdef SHIFT_REGISTER_VALID_EN
    .DataOut2 (DataOut2),
    .Valid    (Valid)
`else
    .DataOut2 (DataOut2)
`endif
  );

  always #5 CLK = ~CLK;

  // Model: history of pixels accepted since reset (last FILL kept) and count.
  int hist[$];
  int nAcc;

  always @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      hist.delete();
      nAcc = 0;
    end else if (Enable) begin
      hist.push_back(int'(DataIn));
      if (hist.size() > FILL) void'(hist.pop_front());
      nAcc = nAcc + 1;
    end
  end

  // Pixel accepted 'lag' enabled edges before the newest one, 0 if none yet.
  function automatic int expTap(int lag);
    if (hist.size() > lag) return hist[hist.size()-1-lag];
    return 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (RST_n) begin
      check("model DataOut2", int'(DataOut2), expTap(0));
      check("model DataOut1", int'(DataOut1), expTap(LL));
      check("model DataOut0", int'(DataOut0), expTap(2*LL));
`ifdef SHIFT_REGISTER_VALID_EN
      check("model Valid", int'(Valid), (nAcc >= FILL) ? 1 : 0);
`endif
    end
  end

  // Drive one cycle's inputs, then return just after the rising edge.
  task automatic push(input logic en, input logic [DW-1:0] d);
    Enable = en;
    DataIn = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOuts(input string name, input int e2, input int e1, input int e0);
    check({name, " DataOut2"}, int'(DataOut2), e2);
    check({name, " DataOut1"}, int'(DataOut1), e1);
    check({name, " DataOut0"}, int'(DataOut0), e0);
  endtask

  task automatic checkValid(input string name, input int e);
`ifdef SHIFT_REGISTER_VALID_EN
    check({name, " Valid"}, int'(Valid), e);
`else
    if (e > 1) $display("bad valid expectation %0d", e);
`endif
  endtask

  // Assert reset between edges, check immediate clear, release before negedge.
  task automatic midReset(input string name);
    #1 RST_n = 1'b0;
    #1;
    checkOuts(name, 0, 0, 0);
    checkValid(name, 0);
    Enable = 1'b0;
    #1 RST_n = 1'b1;
  endtask

  initial begin
    // Reset from time 0.
    #3;
    checkOuts("por", 0, 0, 0);
    checkValid("por", 0);
    @(posedge CLK);
    #4 RST_n = 1'b1;
    @(posedge CLK);
    #1;

    // Pre-fill, stall and ramp.
    for (int i = 1; i <= 3; i++) push(1'b1, DW'(i));
    checkOuts("prefill", 3, 0, 0);
    checkValid("prefill", 0);
    for (int i = 4; i <= 6; i++) push(1'b1, DW'(i));
    checkOuts("before stall", 6, 2, 0);
    for (int i = 0; i < 7; i++) push(1'b0, 8'hEE);
    checkOuts("stall", 6, 2, 0);
    push(1'b1, 8'd7);
    checkOuts("resume", 7, 3, 0);
    push(1'b1, 8'd8);
    checkValid("sample8", 0);
    push(1'b1, 8'd9);
    checkOuts("ramp fill", 9, 5, 1);
    checkValid("ramp fill", 1);
    push(1'b0, 8'h33);
    checkValid("valid hold", 1);
    push(1'b1, 8'd10);

    // Mid-stream reset, then wrap stream.
    midReset("reset1");
    for (int i = 0; i < 600; i++) begin
      push(1'b1, DW'(i));
      if (i >= 2*LL) checkOuts("wrap", i & 255, (i - LL) & 255, (i - 2*LL) & 255);
    end

    // Mid-stream reset, constant refill.
    midReset("reset2");
    for (int k = 1; k <= FILL; k++) begin
      push(1'b1, 8'hA5);
      check("refill DataOut0", int'(DataOut0), (k == FILL) ? 'hA5 : 0);
      checkValid("refill", (k == FILL) ? 1 : 0);
    end
    push(1'b0, 8'h00);
    push(1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
